// File: rtl/ff_input_cond_pkg.sv
// Shared constants, channel map and per-channel output bundle for the cabinet input conditioner.
package ff_input_pkg;

  localparam int FF_TICK_DIV_12M = 12000;
  localparam int FF_DB_CNT_DEF   = 8;
  localparam int FF_NCH_DEF      = 10;

  localparam int CH_TEST    = 0;
  localparam int CH_THROW2  = 1;
  localparam int CH_THROW1  = 2;
  localparam int CH_COINAUX = 3;
  localparam int CH_START2  = 4;
  localparam int CH_START1  = 5;
  localparam int CH_COIN2   = 6;
  localparam int CH_COIN1   = 7;
  localparam int CH_CNTRR   = 8;
  localparam int CH_CNTRL   = 9;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
  } ch_out_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ff_input_cond_if.sv
// Switch-side bus of the input conditioner. The release pulse is called rel because
// "release" is a reserved word.
interface ff_input_cond_if import ff_input_pkg::*; #(
  parameter int NCH = FF_NCH_DEF
);
  logic [NCH-1:0] sw_raw;
  logic [NCH-1:0] sw_db;
  logic [NCH-1:0] press;
  logic [NCH-1:0] rel;
  logic           tick;
  logic           any_active;

  modport master (output sw_raw, input sw_db, press, rel, tick, any_active);
  modport slave  (input sw_raw, output sw_db, press, rel, tick, any_active);
endinterface

// File: rtl/ff_debounce_ch.sv
// One switch channel: 2-flop sync, polarity fix, tick-based debounce, edge pulses.
// Auto-repeat is built only when FF_INPUT_REPEAT_EN is defined and REP_EN is set.
module ff_debounce_ch import ff_input_pkg::*; #(
  parameter bit INV          = 1'b0,
  parameter int DB_CNT       = FF_DB_CNT_DEF,
  parameter bit REP_EN       = 1'b0,
  parameter int REPEAT_DELAY = 400,
  parameter int REPEAT_RATE  = 100
) (
  input  logic    clk12m,
  input  logic    reset_n,
  input  logic    raw_i,
  input  logic    tick_i,
  output ch_out_t out_o
);
  localparam int CW = $clog2(DB_CNT + 1);

  logic          sync1_q, sync2_q;
  logic          s;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          flip;
  logic          rep_hit;

  assign s    = sync2_q ^ INV;
  assign flip = tick_i && (s != db_q) && (cnt_q == CW'(DB_CNT - 1));

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (tick_i) begin
      if (s == db_q) begin
        cnt_d = '0;
      end else if (flip) begin
        cnt_d = '0;
        db_d  = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = (flip && !db_q) || rep_hit;
    rel_d   = flip && db_q;
  end

  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef FF_INPUT_REPEAT_EN
  if (REP_EN) begin : g_rep
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    logic [RW-1:0] rcnt_q, rcnt_inc;
    logic          rphase_q;
    logic          rep_tick;

    // Never repeat on the tick that debounces the release.
    assign rep_tick = tick_i && db_q && !flip;
    assign rcnt_inc = rcnt_q + 1'b1;
    assign rep_hit  = rep_tick &&
                      (rcnt_inc == (rphase_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY)));

    always_ff @(posedge clk12m or negedge reset_n) begin
      if (!reset_n) begin
        rcnt_q   <= '0;
        rphase_q <= 1'b0;
      end else if (!db_q) begin
        rcnt_q   <= '0;
        rphase_q <= 1'b0;
      end else if (rep_tick) begin
        rcnt_q   <= rep_hit ? '0 : rcnt_inc;
        rphase_q <= rphase_q | rep_hit;
      end
    end
  end else begin : g_norep
    assign rep_hit = 1'b0;
  end
`else
  assign rep_hit = 1'b0;
`endif

  assign out_o = '{level: db_q, press: press_q, rel: rel_q};

endmodule

// File: rtl/ff_input_cond.sv
// N-channel cabinet switch conditioner: shared sample-tick prescaler, per-channel debouncers,
// registered any-active flag. Optional auto-repeat via FF_INPUT_REPEAT_EN.
module ff_input_cond import ff_input_pkg::*; #(
  parameter int             NCH          = FF_NCH_DEF,
  parameter logic [NCH-1:0] INV_MASK     = '0,
  parameter int             TICK_DIV     = FF_TICK_DIV_12M,
  parameter int             DB_CNT       = FF_DB_CNT_DEF,
  parameter logic [NCH-1:0] REPEAT_MASK  = '0,
  parameter int             REPEAT_DELAY = 400,
  parameter int             REPEAT_RATE  = 100
) (
  input  logic            clk12m,
  input  logic            reset_n,
  ff_input_cond_if.slave  io
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]  presc_q, presc_d;
  logic           tick_q, tick_d;
  logic           any_q;
  logic [NCH-1:0] db_w, press_w, rel_w;
  ch_out_t        ch_out [NCH];

  // tick is registered from the next count so it is glitch-free and low in reset.
  assign presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + 1'b1;
  assign tick_d  = (presc_d == PW'(TICK_DIV - 1));

  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      any_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      any_q   <= |db_w;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    ff_debounce_ch #(
      .INV          (INV_MASK[gi]),
      .DB_CNT       (DB_CNT),
      .REP_EN       (REPEAT_MASK[gi]),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk12m  (clk12m),
      .reset_n (reset_n),
      .raw_i   (io.sw_raw[gi]),
      .tick_i  (tick_q),
      .out_o   (ch_out[gi])
    );
    assign db_w[gi]    = ch_out[gi].level;
    assign press_w[gi] = ch_out[gi].press;
    assign rel_w[gi]   = ch_out[gi].rel;
  end

  assign io.sw_db      = db_w;
  assign io.press      = press_w;
  assign io.rel        = rel_w;
  assign io.tick       = tick_q;
  assign io.any_active = any_q;

endmodule

// File: tb/tb_ff_input_cond.sv
// Bench for ff_input_cond: window-based model checked every cycle on instance A,
// plus hand-computed expectations on A and on a TICK_DIV=1/DB_CNT=1 instance B.
module tb_ff_input_cond;
  import ff_input_pkg::*;

  localparam int         NCH   = 10;
  localparam int         TD    = 4;
  localparam int         DB    = 3;
  localparam logic [9:0] INV   = 10'h0C0;
  localparam logic [9:0] RMASK = 10'h002;
  localparam int         RD    = 5;
  localparam int         RR    = 2;
  localparam logic [9:0] IDLE  = 10'h0C0;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  always #5 clk = ~clk;

  ff_input_cond_if #(.NCH(NCH)) bus_a ();
  ff_input_cond_if #(.NCH(NCH)) bus_b ();

  ff_input_cond #(
    .NCH(NCH), .INV_MASK(INV), .TICK_DIV(TD), .DB_CNT(DB),
    .REPEAT_MASK(RMASK), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_a (.clk12m(clk), .reset_n(rst_a_n), .io(bus_a));

  ff_input_cond #(
    .NCH(NCH), .INV_MASK('0), .TICK_DIV(1), .DB_CNT(1),
    .REPEAT_MASK('0), .REPEAT_DELAY(400), .REPEAT_RATE(100)
  ) dut_b (.clk12m(clk), .reset_n(rst_b_n), .io(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a level changes once the last DB tick samples all disagree with it.
  logic [9:0] m_r1, m_r2, m_db, m_press, m_rel;
  logic       m_tick, m_any;
  int         m_cyc;
  logic [9:0] m_hist [$];
  int         m_rep_t [NCH];

  task automatic model_reset();
    m_r1 = '0; m_r2 = '0; m_db = '0; m_press = '0; m_rel = '0;
    m_tick = 1'b0; m_any = 1'b0; m_cyc = 0;
    m_hist.delete();
    for (int i = 0; i < NCH; i++) m_rep_t[i] = 0;
  endtask

  task automatic model_step();
    logic [9:0] s_pre, db_next, pr, rl;
    bit         all_dis;
    s_pre = m_r2 ^ INV;
    db_next = m_db; pr = '0; rl = '0;
    if (m_tick) begin
      m_hist.push_back(s_pre);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      for (int i = 0; i < NCH; i++) begin
        all_dis = (m_hist.size() == DB);
        foreach (m_hist[j]) if (m_hist[j][i] == m_db[i]) all_dis = 0;
        if (all_dis) begin
          db_next[i] = ~m_db[i];
          if (db_next[i]) begin
            pr[i] = 1'b1;
            m_rep_t[i] = 0;
          end else begin
            rl[i] = 1'b1;
          end
        end else if (m_db[i]) begin
          m_rep_t[i]++;
`ifdef FF_INPUT_REPEAT_EN
          if (RMASK[i] && (m_rep_t[i] == RD ||
                           (m_rep_t[i] > RD && (m_rep_t[i] - RD) % RR == 0)))
            pr[i] = 1'b1;
`endif
        end
      end
    end
    m_any   = |m_db;
    m_db    = db_next;
    m_press = pr;
    m_rel   = rl;
    m_r2    = m_r1;
    m_r1    = bus_a.sw_raw;
    m_cyc++;
    m_tick  = ((m_cyc % TD) == TD - 1);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_a_n);
      if (!rst_a_n) model_reset();
      else          model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("a_sw_db",   bus_a.sw_db,      m_db);
      chk("a_press",   bus_a.press,      m_press);
      chk("a_release", bus_a.rel,        m_rel);
      chk("a_tick",    bus_a.tick,       m_tick);
      chk("a_any",     bus_a.any_active, m_any);
    end
  end

  task automatic at_edge(input int k);
    int guard = 0;
    while (m_cyc < k && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) chk("edge_timeout", 32'(m_cyc), 32'(k));
  endtask

  task automatic look(input int k);
    at_edge(k);
    @(negedge clk);
  endtask

  initial begin
    bus_a.sw_raw = 10'h33F;
    bus_b.sw_raw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sw_db",   bus_a.sw_db, 0);
    chk("rst_press",   bus_a.press, 0);
    chk("rst_release", bus_a.rel, 0);
    chk("rst_tick",    bus_a.tick, 0);
    chk("rst_any",     bus_a.any_active, 0);
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Switches held through reset come up as presses after three ticks.
    look(11);  chk("pre_sw_db", bus_a.sw_db, 0);
    look(12);  chk("init_sw_db", bus_a.sw_db, 10'h3FF);
               chk("init_press", bus_a.press, 10'h3FF);
    look(13);  chk("init_press_end", bus_a.press, 0);
               chk("init_any", bus_a.any_active, 1);
    at_edge(14); bus_a.sw_raw = IDLE;
    look(28);  chk("all_release", bus_a.rel, 10'h3FF);
               chk("all_off", bus_a.sw_db, 0);

    at_edge(30); bus_a.sw_raw[CH_THROW1] = 1'b1;
    look(43);  chk("ch2_not_yet", bus_a.sw_db, 0);
    look(44);  chk("ch2_press", bus_a.press, 10'h004);
               chk("ch2_level", bus_a.sw_db, 10'h004);
    look(45);  chk("ch2_press_end", bus_a.press, 0);
    at_edge(50); bus_a.sw_raw[CH_THROW1] = 1'b0;
    look(64);  chk("ch2_release", bus_a.rel, 10'h004);

    at_edge(66); bus_a.sw_raw[CH_COIN1] = 1'b0;
    at_edge(76); bus_a.sw_raw[CH_COIN1] = 1'b1;
    look(84);  chk("ch7_glitch", bus_a.sw_db, 0);
    at_edge(86); bus_a.sw_raw[CH_COIN1] = 1'b0;
    look(100); chk("ch7_press", bus_a.press, 10'h080);
    at_edge(102); bus_a.sw_raw[CH_COIN1] = 1'b1;
    look(116); chk("ch7_release", bus_a.rel, 10'h080);

    at_edge(118); bus_a.sw_raw[CH_COIN2] = 1'b0;
    look(132); chk("ch6_inv_level", bus_a.sw_db, 10'h040);
               chk("ch6_inv_press", bus_a.press, 10'h040);
    at_edge(134); bus_a.sw_raw[CH_COIN2] = 1'b1;
    look(148); chk("ch6_inv_release", bus_a.rel, 10'h040);

    at_edge(150);
    bus_a.sw_raw[CH_TEST] = 1'b1;
    bus_a.sw_raw[CH_START1] = 1'b1;
    bus_a.sw_raw[CH_CNTRL] = 1'b1;
    look(164); chk("multi_press", bus_a.press, 10'h221);
               chk("multi_any_lag", bus_a.any_active, 0);
    look(165); chk("multi_any", bus_a.any_active, 1);
    at_edge(166); bus_a.sw_raw = IDLE;
    look(180); chk("multi_release", bus_a.rel, 10'h221);

    at_edge(182); bus_a.sw_raw[CH_THROW2] = 1'b1;
    look(196); chk("rep_first", bus_a.press, 10'h002);
`ifdef FF_INPUT_REPEAT_EN
    look(216); chk("rep_delay", bus_a.press, 10'h002);
    look(224); chk("rep_rate", bus_a.press, 10'h002);
`else
    look(216); chk("no_rep_delay", bus_a.press, 0);
    look(224); chk("no_rep_rate", bus_a.press, 0);
`endif
    at_edge(242); bus_a.sw_raw[CH_THROW2] = 1'b0;
    look(256); chk("rep_release", bus_a.rel, 10'h002);
               chk("rep_stop", bus_a.press, 0);

    // Reset with ch3 two ticks into its debounce: nothing may come out.
    at_edge(270); bus_a.sw_raw[CH_COINAUX] = 1'b1;
    at_edge(281);
    rst_a_n = 1'b0;
    bus_a.sw_raw = IDLE;
    @(negedge clk);
    chk("mid_rst_sw_db", bus_a.sw_db, 0);
    repeat (2) @(posedge clk);
    #1 rst_a_n = 1'b1;
    look(20);  chk("mid_rst_quiet", bus_a.sw_db, 0);
               chk("mid_rst_nopress", bus_a.press, 0);

    // Instance B: sw_db follows s one cycle later.
    @(posedge clk); #1;
    bus_b.sw_raw = 10'h100;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("b_tick", bus_b.tick, 1);
                    chk("b_s_only", bus_b.sw_db, 0);
    @(negedge clk); chk("b_level", bus_b.sw_db, 10'h100);
                    chk("b_press", bus_b.press, 10'h100);
    @(negedge clk); chk("b_press_end", bus_b.press, 0);
                    chk("b_any", bus_b.any_active, 1);
    bus_b.sw_raw = '0;
    @(negedge clk);
    @(negedge clk); chk("b_hold", bus_b.sw_db, 10'h100);
    @(negedge clk); chk("b_release", bus_b.rel, 10'h100);
                    chk("b_off", bus_b.sw_db, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
